// File: rtl/game_pkg.sv
// Shared game definitions used by the number-grid collision logic.
//   hit_state_t    : states of the per-frame hit resolver
//   NUM_COUNT_MAX  : most number sprites an index can address
//   IDX_W          : width of a number index
//   HOLDOFF_CNT_W  : width of the frame hold-off counter
package game_pkg;

    localparam int unsigned NUM_COUNT_MAX = 16;
    localparam int unsigned IDX_W         = 4;
    localparam int unsigned HOLDOFF_CNT_W = 8;

    typedef enum logic [1:0] {
        ARMED,
        HIT,
        HOLDOFF
    } hit_state_t;

endpackage

// File: rtl/lowest_bit_encoder.sv
// Priority encoder: reports the index of the lowest set bit of vec.
//   vec   in  WIDTH  input vector
//   idx   out IDX_W  index of the lowest set bit (0 when vec is zero)
//   valid out 1      high when any bit of vec is set
module lowest_bit_encoder #(
    parameter int unsigned WIDTH = 12,
    parameter int unsigned IDX_W = 4
) (
    input  logic [WIDTH-1:0] vec,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    always_comb begin
        idx   = '0;
        valid = |vec;
        // Scan downward so the lowest set bit is the last assignment.
        for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/number_hit_detector.sv
// Resolves at most one player/number collision per frame and reports it at
// the following frame boundary, with a per-number hit mask and a frame hold-off.
//   clk           in  pixel clock
//   reset         in  synchronous active-high reset
//   startOfFrame  in  one-cycle pulse at the first pixel of a frame
//   playerDR      in  player drawing request for the current pixel
//   numbersDR     in  per-number drawing requests
//   clearMask     in  one-cycle re-arm of all numbers
//   singleHit     out one-cycle pulse: hit resolved for the previous frame
//   hitIndex      out index of the last resolved hit
//   hitMask       out numbers already hit
//   allHit        out every number has been hit
module number_hit_detector
    import game_pkg::*;
#(
    parameter int unsigned NUM_COUNT      = 12,
    parameter int unsigned HOLDOFF_FRAMES = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 startOfFrame,
    input  logic                 playerDR,
    input  logic [NUM_COUNT-1:0] numbersDR,
    input  logic                 clearMask,
    output logic                 singleHit,
    output logic [IDX_W-1:0]     hitIndex,
    output logic [NUM_COUNT-1:0] hitMask,
    output logic                 allHit
);

    localparam logic [HOLDOFF_CNT_W-1:0] CntLoad = HOLDOFF_CNT_W'(HOLDOFF_FRAMES);
    // Value left after the tick taken when a frame starts during HIT.
    localparam logic [HOLDOFF_CNT_W-1:0] CntLoadTick =
        (CntLoad > 1) ? CntLoad - HOLDOFF_CNT_W'(1) : '0;

    hit_state_t               state_q, state_d;
    logic                     pend_valid_q, pend_valid_d;
    logic [IDX_W-1:0]         pend_idx_q, pend_idx_d;
    logic [HOLDOFF_CNT_W-1:0] cnt_q, cnt_d;
    logic [NUM_COUNT-1:0]     mask_q, mask_d;
    logic [IDX_W-1:0]         hit_index_q, hit_index_d;

    logic [NUM_COUNT-1:0]     cand;
    logic [IDX_W-1:0]         cand_idx;
    logic                     cand_valid;
    logic                     sample;

    assign cand = numbersDR & ~mask_q & {NUM_COUNT{playerDR}};

    lowest_bit_encoder #(
        .WIDTH (NUM_COUNT),
        .IDX_W (IDX_W)
    ) u_enc (
        .vec   (cand),
        .idx   (cand_idx),
        .valid (cand_valid)
    );

    always_comb begin
        state_d      = state_q;
        pend_valid_d = pend_valid_q;
        pend_idx_d   = pend_idx_q;
        cnt_d        = cnt_q;
        mask_d       = mask_q;
        hit_index_d  = hit_index_q;
        sample       = 1'b0;

        if (clearMask) begin
            state_d      = ARMED;
            pend_valid_d = 1'b0;
            cnt_d        = '0;
            mask_d       = '0;
        end else begin
            unique case (state_q)
                ARMED: begin
                    if (startOfFrame && pend_valid_q) begin
                        state_d      = HIT;
                        mask_d       = mask_q | (NUM_COUNT'(1) << pend_idx_q);
                        hit_index_d  = pend_idx_q;
                        pend_valid_d = 1'b0;
                    end else begin
                        sample = 1'b1;
                    end
                end
                HIT: begin
                    if (startOfFrame && CntLoad <= 1) begin
                        state_d = ARMED;
                        cnt_d   = '0;
                        sample  = 1'b1;
                    end else begin
                        state_d = HOLDOFF;
                        cnt_d   = startOfFrame ? CntLoadTick : CntLoad;
                    end
                end
                HOLDOFF: begin
                    if (startOfFrame) begin
                        if (cnt_q <= 1) begin
                            // Last hold-off frame elapsed: this new frame is armed.
                            state_d = ARMED;
                            cnt_d   = '0;
                            sample  = 1'b1;
                        end else begin
                            cnt_d = cnt_q - HOLDOFF_CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = ARMED;
                end
            endcase

            // First collision of an armed frame wins; later ones are ignored.
            if (sample && !pend_valid_q && cand_valid) begin
                pend_valid_d = 1'b1;
                pend_idx_d   = cand_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ARMED;
            pend_valid_q <= 1'b0;
            pend_idx_q   <= '0;
            cnt_q        <= '0;
            mask_q       <= '0;
            hit_index_q  <= '0;
        end else begin
            state_q      <= state_d;
            pend_valid_q <= pend_valid_d;
            pend_idx_q   <= pend_idx_d;
            cnt_q        <= cnt_d;
            mask_q       <= mask_d;
            hit_index_q  <= hit_index_d;
        end
    end

    assign singleHit = (state_q == HIT);
    assign hitIndex  = hit_index_q;
    assign hitMask   = mask_q;
    assign allHit    = &mask_q;

endmodule
